// File: rtl/node_endpoint.sv
`default_nettype none
// ============================================================================
//  Module   : node_endpoint
//  Purpose  : Terminal network interface for the east/west node chain.
//             Injects local flits onto the chain (paced, no backpressure)
//             and ejects chain flits into a first-word fall-through buffer
//             with saturating drop accounting.
//  Revision : 1.0 - initial release
// ============================================================================
module node_endpoint #(
  parameter int DEPTH   = 4,  // entries per FIFO, power of 2, >= 2
  parameter int MIN_GAP = 0,  // idle cycles forced between tx pulses
  parameter int CNT_W   = 8,  // drop counter width
  parameter int FLIT_W  = 7   // flit width carried on the link
) (
  input  logic              clk,
  input  logic              rst,
  // link toward the chain (injection)
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_enable,
  // link from the chain (ejection)
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              rx_enable,
  // local injection side
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  // local ejection side
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  // statistics
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  // Gap counter must hold MIN_GAP; the +2 keeps the width >= 1 when MIN_GAP is 0.
  localparam int c_GAP_W  = $clog2(MIN_GAP + 2);
  localparam logic [c_GAP_W-1:0]  c_GAP_LOAD = c_GAP_W'(MIN_GAP);
  localparam logic [c_GAP_W-1:0]  c_GAP_ONE  = c_GAP_W'(1);
  localparam logic [c_ADDR_W:0]   c_PTR_ONE  = (c_ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [FLIT_W-1:0]  r_tx_mem [DEPTH];
  logic [c_ADDR_W:0]  r_tx_wr;
  logic [c_ADDR_W:0]  r_tx_rd;
  logic               w_tx_empty;
  logic               w_tx_full;
  logic               w_tx_push;
  logic               w_tx_pop;
  logic [FLIT_W-1:0]  w_tx_head;

  state_t              r_state;
  logic [c_GAP_W-1:0]  r_gap_cnt;

  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[c_ADDR_W] != r_tx_rd[c_ADDR_W]) &&
                      (r_tx_wr[c_ADDR_W-1:0] == r_tx_rd[c_ADDR_W-1:0]);
  // A full FIFO refuses a push even if the FSM frees a slot this cycle.
  assign w_tx_push  = in_valid && !w_tx_full;
  assign in_ready   = !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rd[c_ADDR_W-1:0]];

  // Decide whether the FSM launches a new flit this cycle.
  always_comb begin
    w_tx_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_tx_pop = !w_tx_empty;
      S_SEND:  w_tx_pop = (MIN_GAP == 0) && !w_tx_empty;
      // Last gap cycle launches directly so pulses are MIN_GAP+1 cycles apart.
      S_GAP:   w_tx_pop = (r_gap_cnt == c_GAP_ONE) && !w_tx_empty;
      default: w_tx_pop = 1'b0;
    endcase
  end

  // TX storage write port.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[c_ADDR_W-1:0]] <= in_flit;
  end

  // TX pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
    end
  end

  // Injection FSM with registered link outputs; flit holds while enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      tx_enable <= 1'b0;
      tx_flit   <= '0;
    end else if (w_tx_pop) begin
      r_state   <= S_SEND;
      tx_enable <= 1'b1;
      tx_flit   <= w_tx_head;
    end else begin
      tx_enable <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_SEND: begin
          if (MIN_GAP > 0) begin
            r_state   <= S_GAP;
            r_gap_cnt <= c_GAP_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_GAP_ONE) r_state <= S_IDLE;
          else                        r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic [FLIT_W-1:0]  r_rx_mem [DEPTH];
  logic [c_ADDR_W:0]  r_rx_wr;
  logic [c_ADDR_W:0]  r_rx_rd;
  logic               w_rx_empty;
  logic               w_rx_full;
  logic               w_rx_push;
  logic               w_rx_pop;
  logic               w_rx_drop;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[c_ADDR_W] != r_rx_rd[c_ADDR_W]) &&
                      (r_rx_wr[c_ADDR_W-1:0] == r_rx_rd[c_ADDR_W-1:0]);
  assign out_valid  = !w_rx_empty;
  assign out_flit   = r_rx_mem[r_rx_rd[c_ADDR_W-1:0]];
  assign w_rx_pop   = out_valid && out_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign w_rx_push  = rx_enable && (!w_rx_full || w_rx_pop);
  assign w_rx_drop  = rx_enable && !w_rx_push;

  // RX storage write port; when full+pop, the written slot is the one being read out.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[c_ADDR_W-1:0]] <= rx_flit;
  end

  // RX pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_PTR_ONE;
    end
  end

  // Drop statistics: saturating counter and sticky flag; a drop during clear still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr_stats) begin
      drop_count <= w_rx_drop ? c_CNT_ONE : '0;
      overflow   <= w_rx_drop;
    end else if (w_rx_drop) begin
      if (drop_count != '1) drop_count <= drop_count + c_CNT_ONE;
      overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_node_endpoint.sv
`default_nettype none
// ============================================================================
//  Module   : tb_node_endpoint
//  Purpose  : Directed self-checking bench for node_endpoint with queue-based
//             expected results (injection pacing, RX drops, reset, loopback).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_node_endpoint;

  localparam int FW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: MIN_GAP=0, rx driven by bench, tx feeds instance B
  logic [FW-1:0] a_in_flit, a_rx_flit, a_tx_flit, a_out_flit;
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic          a_rx_en, a_tx_en, a_clr, a_ovf;
  logic [7:0]    a_drop;
  // Instance B: receiver end of the loopback chain
  logic [FW-1:0] b_in_flit, b_tx_flit, b_out_flit;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic          b_tx_en, b_clr, b_ovf;
  logic [7:0]    b_drop;
  // Instance G: MIN_GAP=2 pacing
  logic [FW-1:0] g_in_flit, g_rx_flit, g_tx_flit, g_out_flit;
  logic          g_in_valid, g_in_ready, g_out_valid, g_out_ready;
  logic          g_rx_en, g_tx_en, g_clr, g_ovf;
  logic [7:0]    g_drop;

  node_endpoint #(.DEPTH(4), .MIN_GAP(0), .CNT_W(8), .FLIT_W(FW)) u_a (
    .clk(clk), .rst(rst),
    .tx_flit(a_tx_flit), .tx_enable(a_tx_en),
    .rx_flit(a_rx_flit), .rx_enable(a_rx_en),
    .in_flit(a_in_flit), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_flit(a_out_flit), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .clr_stats(a_clr), .drop_count(a_drop), .overflow(a_ovf));

  node_endpoint #(.DEPTH(4), .MIN_GAP(0), .CNT_W(8), .FLIT_W(FW)) u_b (
    .clk(clk), .rst(rst),
    .tx_flit(b_tx_flit), .tx_enable(b_tx_en),
    .rx_flit(a_tx_flit), .rx_enable(a_tx_en),
    .in_flit(b_in_flit), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_flit(b_out_flit), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .clr_stats(b_clr), .drop_count(b_drop), .overflow(b_ovf));

  node_endpoint #(.DEPTH(4), .MIN_GAP(2), .CNT_W(8), .FLIT_W(FW)) u_g (
    .clk(clk), .rst(rst),
    .tx_flit(g_tx_flit), .tx_enable(g_tx_en),
    .rx_flit(g_rx_flit), .rx_enable(g_rx_en),
    .in_flit(g_in_flit), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .out_flit(g_out_flit), .out_valid(g_out_valid), .out_ready(g_out_ready),
    .clr_stats(g_clr), .drop_count(g_drop), .overflow(g_ovf));

  int n_checks = 0;
  int n_errors = 0;

  logic [FW-1:0] tx_q[$];   // expected flits on A's tx link
  logic [FW-1:0] bq[$];     // expected flits out of B
  logic [FW-1:0] aq[$];     // expected flits out of A's RX FIFO
  logic [FW-1:0] lq[$];     // loopback scoreboard

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pop_or_none(inout logic [FW-1:0] q[$]);
    if (q.size() == 0) return 32'hFFFF_FFFF;
    return 32'(q.pop_front());
  endfunction

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, gap, en_cnt;
    logic [31:0] exp;

    rst = 1'b1;
    a_in_flit = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_rx_flit = '0; a_rx_en = 1'b0; a_clr = 1'b0;
    b_in_flit = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_clr = 1'b0;
    g_in_flit = '0; g_in_valid = 1'b0; g_out_ready = 1'b0; g_rx_flit = '0; g_rx_en = 1'b0; g_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // ---- reset state
    check("rst_tx_en",    32'(a_tx_en),     32'd0);
    check("rst_tx_flit",  32'(a_tx_flit),   32'd0);
    check("rst_in_ready", 32'(a_in_ready),  32'd1);
    check("rst_out_valid",32'(a_out_valid), 32'd0);
    check("rst_drop",     32'(a_drop),      32'd0);
    check("rst_overflow", 32'(a_ovf),       32'd0);

    // ---- test 1: back-to-back injection, MIN_GAP=0
    a_in_valid = 1'b1; a_in_flit = 7'h11; tx_q.push_back(7'h11);
    tick();
    check("t1_latency_low", 32'(a_tx_en), 32'd0);
    a_in_flit = 7'h22; tx_q.push_back(7'h22);
    tick();
    check("t1_en0", 32'(a_tx_en), 32'd1);
    bq.push_back(a_tx_flit);
    check("t1_flit0", 32'(a_tx_flit), pop_or_none(tx_q));
    a_in_flit = 7'h33; tx_q.push_back(7'h33);
    tick();
    a_in_valid = 1'b0;
    check("t1_en1", 32'(a_tx_en), 32'd1);
    bq.push_back(a_tx_flit);
    check("t1_flit1", 32'(a_tx_flit), pop_or_none(tx_q));
    tick();
    check("t1_en2", 32'(a_tx_en), 32'd1);
    bq.push_back(a_tx_flit);
    check("t1_flit2", 32'(a_tx_flit), pop_or_none(tx_q));
    tick();
    check("t1_en_off",  32'(a_tx_en),     32'd0);
    check("t1_hold",    32'(a_tx_flit),   32'h33);
    check("t1_drained", 32'(tx_q.size()), 32'd0);
    // B got the three flits through the link in order
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_b_valid", 32'(b_out_valid), 32'd1);
      check("t1_b_flit",  32'(b_out_flit),  pop_or_none(bq));
      tick();
    end
    check("t1_b_empty", 32'(b_out_valid), 32'd0);
    b_out_ready = 1'b0;

    // ---- test 2: MIN_GAP=2 pacing
    g_in_valid = 1'b1; g_in_flit = 7'h05;
    tick();
    g_in_flit = 7'h06;
    tick();
    g_in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("t2_en", 32'(g_tx_en), 32'((i == 0) || (i == 3)));
      if (i == 0) check("t2_flit0", 32'(g_tx_flit), 32'h05);
      if (i == 3) check("t2_flit1", 32'(g_tx_flit), 32'h06);
      tick();
    end

    // ---- test 3: RX overflow with consumer stalled
    a_out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      a_rx_en = 1'b1; a_rx_flit = 7'(i);
      if (i <= 4) aq.push_back(7'(i));
      tick();
    end
    a_rx_en = 1'b0;
    check("t3_drop",     32'(a_drop),      32'd2);
    check("t3_overflow", 32'(a_ovf),       32'd1);
    check("t3_valid",    32'(a_out_valid), 32'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("t3_clr_drop", 32'(a_drop), 32'd0);
    check("t3_clr_ovf",  32'(a_ovf),  32'd0);

    // ---- test 4: full FIFO, simultaneous pop and arrival -> no drop
    a_out_ready = 1'b1; a_rx_en = 1'b1; a_rx_flit = 7'h7F;
    #1;
    check("t4_head", 32'(a_out_flit), pop_or_none(aq));
    aq.push_back(7'h7F);
    tick();
    a_rx_en = 1'b0;
    check("t4_nodrop", 32'(a_drop), 32'd0);
    check("t4_noovf",  32'(a_ovf),  32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t4_valid", 32'(a_out_valid), 32'd1);
      check("t4_flit",  32'(a_out_flit),  pop_or_none(aq));
      tick();
    end
    check("t4_empty", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;

    // ---- clear and drop in the same cycle
    for (int i = 0; i < 4; i++) begin
      a_rx_en = 1'b1; a_rx_flit = 7'(8'h40 + i);
      tick();
    end
    a_clr = 1'b1; a_rx_flit = 7'h50;
    tick();
    a_clr = 1'b0; a_rx_en = 1'b0;
    check("clr_drop_cnt", 32'(a_drop), 32'd1);
    check("clr_drop_ovf", 32'(a_ovf),  32'd1);

    // ---- test 5: reset during SEND with flits still queued
    a_in_valid = 1'b1; a_in_flit = 7'h61; tick();
    a_in_flit = 7'h62; tick();
    a_in_flit = 7'h63; tick();
    a_in_valid = 1'b0;
    check("t5_in_send", 32'(a_tx_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_en_low",   32'(a_tx_en),     32'd0);
    check("t5_in_ready", 32'(a_in_ready),  32'd1);
    check("t5_out_valid",32'(a_out_valid), 32'd0);
    check("t5_drop",     32'(a_drop),      32'd0);
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_tx_en) en_cnt++;
      tick();
    end
    check("t5_quiet", 32'(en_cnt), 32'd0);

    // ---- test 6: loopback A -> B with random consumer stalls
    sent = 0; got = 0; gap = 0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      if (sent < 10 && gap == 0) begin
        a_in_valid = 1'b1; a_in_flit = 7'($urandom);
      end else begin
        a_in_valid = 1'b0;
      end
      b_out_ready = (cyc % 2 == 0) ? 1'b1 : 1'($urandom % 2);
      #1;
      if (a_in_valid && a_in_ready) begin
        lq.push_back(a_in_flit); sent++; gap = 2;
      end else if (gap > 0) begin
        gap--;
      end
      if (b_out_valid && b_out_ready) begin
        exp = pop_or_none(lq);
        check("t6_order", 32'(b_out_flit), exp);
        got++;
      end
      tick();
    end
    a_in_valid = 1'b0; b_out_ready = 1'b0;
    check("t6_count",    32'(got),       32'd10);
    check("t6_leftover", 32'(lq.size()), 32'd0);
    check("t6_drop",     32'(b_drop),    32'd0);
    check("t6_overflow", 32'(b_ovf),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
